// File: rtl/xbutton_ctrl.sv
// Push-button peripheral: synchronises and debounces raw buttons, latches press
// events in sticky flags and a saturating counter, and raises a maskable interrupt.
module xbutton_ctrl #(
    parameter int N_BTN        = 2,
    parameter int DEBOUNCE_CYC = 1000,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sel,
    input  logic             we,
    input  logic [1:0]       addr,
    input  logic [31:0]      data_in,
    output logic [31:0]      data_out,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_state,
    output logic             irq
);

    localparam int                DB_W    = $clog2(DEBOUNCE_CYC);
    localparam logic [DB_W-1:0]   DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    logic [N_BTN-1:0] r_sync1;
    logic [N_BTN-1:0] r_sync2;
    logic [N_BTN-1:0] r_stable;
    logic [N_BTN-1:0] r_pressed;
    logic [N_BTN-1:0] r_irqEn;
    logic [DB_W-1:0]  r_dbCnt [N_BTN];
    logic [CNT_W-1:0] r_count;
    logic             r_irq;

    logic [N_BTN-1:0] w_stableNext;
    logic [DB_W-1:0]  w_dbCntNext [N_BTN];
    logic [N_BTN-1:0] w_rise;
    logic [N_BTN-1:0] w_w1cMask;
    logic [3:0]       w_riseCount;
    logic [CNT_W+3:0] w_countSum;
    logic             w_wrPressed;
    logic             w_wrCount;
    logic             w_wrIrqEn;
    logic             w_unusedData;

    assign w_wrPressed  = sel & we & (addr == 2'd1);
    assign w_wrCount    = sel & we & (addr == 2'd2);
    assign w_wrIrqEn    = sel & we & (addr == 2'd3);
    assign w_w1cMask    = w_wrPressed ? data_in[N_BTN-1:0] : '0;
    assign w_unusedData = ^data_in[31:N_BTN];

    // Counter runs only while the synchronised input disagrees with the stable level;
    // any agreement (including a bounce back) restarts the qualification window.
    always_comb begin
        w_stableNext = r_stable;
        for (int i = 0; i < N_BTN; i++) begin
            w_dbCntNext[i] = '0;
            if (r_sync2[i] != r_stable[i]) begin
                if (r_dbCnt[i] == DB_LAST) begin
                    w_stableNext[i] = r_sync2[i];
                end else begin
                    w_dbCntNext[i] = r_dbCnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_rise = w_stableNext & ~r_stable;

    always_comb begin
        w_riseCount = '0;
        for (int i = 0; i < N_BTN; i++) begin
            w_riseCount = w_riseCount + 4'(w_rise[i]);
        end
        w_countSum = {4'b0, r_count} + {{CNT_W{1'b0}}, w_riseCount};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_stable  <= '0;
            r_pressed <= '0;
            r_irqEn   <= '0;
            r_count   <= '0;
            r_irq     <= 1'b0;
            for (int i = 0; i < N_BTN; i++) begin
                r_dbCnt[i] <= '0;
            end
        end else begin
            r_sync1  <= btn_raw;
            r_sync2  <= r_sync1;
            r_stable <= w_stableNext;
            for (int i = 0; i < N_BTN; i++) begin
                r_dbCnt[i] <= w_dbCntNext[i];
            end
            // A new rise overrides a same-cycle W1C so no press is ever lost.
            r_pressed <= (r_pressed & ~w_w1cMask) | w_rise;
            if (w_wrCount) begin
                r_count <= '0;
            end else if (w_countSum > {4'b0, CNT_MAX}) begin
                r_count <= CNT_MAX;
            end else begin
                r_count <= w_countSum[CNT_W-1:0];
            end
            if (w_wrIrqEn) begin
                r_irqEn <= data_in[N_BTN-1:0];
            end
            r_irq <= |(r_pressed & r_irqEn);
        end
    end

    always_comb begin
        data_out = '0;
        if (sel) begin
            case (addr)
                2'd0:    data_out[N_BTN-1:0] = r_stable;
                2'd1:    data_out[N_BTN-1:0] = r_pressed;
                2'd2:    data_out[CNT_W-1:0] = r_count;
                default: data_out[N_BTN-1:0] = r_irqEn;
            endcase
        end
    end

    assign btn_state = r_stable;
    assign irq       = r_irq;

endmodule

// File: tb/tb_xbutton_ctrl.sv
// Directed bench for xbutton_ctrl with DEBOUNCE_CYC=4 and CNT_W=2 so that
// latency, bounce filtering and counter saturation are quick to reach.
module tb_xbutton_ctrl;

    logic        clk;
    logic        rst;
    logic        sel;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic [1:0]  btn_raw;
    logic [1:0]  btn_state;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    xbutton_ctrl #(
        .N_BTN(2),
        .DEBOUNCE_CYC(4),
        .CNT_W(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sel(sel),
        .we(we),
        .addr(addr),
        .data_in(data_in),
        .data_out(data_out),
        .btn_raw(btn_raw),
        .btn_state(btn_state),
        .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic readReg(input logic [1:0] a, output logic [31:0] d);
        sel  = 1'b1;
        we   = 1'b0;
        addr = a;
        #1;
        d    = data_out;
        sel  = 1'b0;
        addr = 2'd0;
    endtask

    // Called at a negedge; the write lands on the following posedge.
    task automatic writeReg(input logic [1:0] a, input logic [31:0] d);
        sel     = 1'b1;
        we      = 1'b1;
        addr    = a;
        data_in = d;
        @(negedge clk);
        sel     = 1'b0;
        we      = 1'b0;
        data_in = '0;
    endtask

    task automatic test_reset;
        logic [31:0] rd;
        rst = 1'b0; sel = 1'b0; we = 1'b0; addr = 2'd0; data_in = '0;
        btn_raw = 2'b11;
        tick(3);
        checks++;
        if (irq !== 1'b0) begin failures++; $display("[TB] FAIL reset_irq got=%0b exp=0", irq); end
        checks++;
        if (btn_state !== 2'b00) begin failures++; $display("[TB] FAIL reset_btn_state got=%0b exp=00", btn_state); end
        for (int a = 0; a < 4; a++) begin
            readReg(2'(a), rd);
            checks++;
            if (rd !== 32'd0) begin failures++; $display("[TB] FAIL reset_reg%0d got=%0h exp=0", a, rd); end
        end
        rst = 1'b1;
        tick(5);
        checks++;
        if (btn_state !== 2'b00) begin failures++; $display("[TB] FAIL latency_early got=%0b exp=00", btn_state); end
        tick(1);
        checks++;
        if (btn_state !== 2'b11) begin failures++; $display("[TB] FAIL latency_exact got=%0b exp=11", btn_state); end
        readReg(2'd1, rd);
        checks++;
        if (rd !== 32'd3) begin failures++; $display("[TB] FAIL reset_pressed got=%0h exp=3", rd); end
        readReg(2'd2, rd);
        checks++;
        if (rd !== 32'd2) begin failures++; $display("[TB] FAIL reset_count got=%0h exp=2", rd); end
        btn_raw = 2'b00;
        tick(8);
        checks++;
        if (btn_state !== 2'b00) begin failures++; $display("[TB] FAIL release_state got=%0b exp=00", btn_state); end
        writeReg(2'd1, 32'd3);
        writeReg(2'd2, 32'd0);
        readReg(2'd1, rd);
        checks++;
        if (rd !== 32'd0) begin failures++; $display("[TB] FAIL w1c_clear got=%0h exp=0", rd); end
    endtask

    task automatic test_bounce;
        logic [31:0] rd;
        for (int i = 0; i < 5; i++) begin
            btn_raw[0] = 1'b1; tick(2);
            btn_raw[0] = 1'b0; tick(2);
        end
        checks++;
        if (btn_state !== 2'b00) begin failures++; $display("[TB] FAIL bounce_filtered got=%0b exp=00", btn_state); end
        btn_raw[0] = 1'b1;
        tick(8);
        checks++;
        if (btn_state !== 2'b01) begin failures++; $display("[TB] FAIL bounce_settled got=%0b exp=01", btn_state); end
        readReg(2'd2, rd);
        checks++;
        if (rd !== 32'd1) begin failures++; $display("[TB] FAIL bounce_count got=%0h exp=1", rd); end
        readReg(2'd1, rd);
        checks++;
        if (rd !== 32'd1) begin failures++; $display("[TB] FAIL bounce_pressed got=%0h exp=1", rd); end
        btn_raw[0] = 1'b0; tick(3); btn_raw[0] = 1'b1;
        btn_raw[1] = 1'b1; tick(3); btn_raw[1] = 1'b0;
        tick(8);
        checks++;
        if (btn_state !== 2'b01) begin failures++; $display("[TB] FAIL glitch_state got=%0b exp=01", btn_state); end
        readReg(2'd2, rd);
        checks++;
        if (rd !== 32'd1) begin failures++; $display("[TB] FAIL glitch_count got=%0h exp=1", rd); end
        readReg(2'd1, rd);
        checks++;
        if (rd !== 32'd1) begin failures++; $display("[TB] FAIL glitch_pressed got=%0h exp=1", rd); end
        btn_raw[0] = 1'b0;
        tick(8);
        readReg(2'd2, rd);
        checks++;
        if (rd !== 32'd1) begin failures++; $display("[TB] FAIL release_no_count got=%0h exp=1", rd); end
        writeReg(2'd1, 32'd3);
        writeReg(2'd2, 32'd0);
    endtask

    task automatic test_w1c_race;
        logic [31:0] rd;
        btn_raw[0] = 1'b1;
        tick(5);
        writeReg(2'd1, 32'd1);
        readReg(2'd1, rd);
        checks++;
        if (rd !== 32'd1) begin failures++; $display("[TB] FAIL race_set_wins got=%0h exp=1", rd); end
        readReg(2'd2, rd);
        checks++;
        if (rd !== 32'd1) begin failures++; $display("[TB] FAIL race_count got=%0h exp=1", rd); end
        writeReg(2'd1, 32'd1);
        readReg(2'd1, rd);
        checks++;
        if (rd !== 32'd0) begin failures++; $display("[TB] FAIL race_later_clear got=%0h exp=0", rd); end
        btn_raw[1] = 1'b1;
        tick(5);
        writeReg(2'd2, 32'd0);
        readReg(2'd2, rd);
        checks++;
        if (rd !== 32'd0) begin failures++; $display("[TB] FAIL count_clear_wins got=%0h exp=0", rd); end
        readReg(2'd1, rd);
        checks++;
        if (rd !== 32'd2) begin failures++; $display("[TB] FAIL count_race_pressed got=%0h exp=2", rd); end
        btn_raw = 2'b00;
        tick(8);
        writeReg(2'd1, 32'd3);
    endtask

    task automatic test_saturation;
        logic [31:0] rd;
        for (int i = 0; i < 5; i++) begin
            btn_raw[0] = 1'b1; tick(8);
            btn_raw[0] = 1'b0; tick(8);
        end
        readReg(2'd2, rd);
        checks++;
        if (rd !== 32'd3) begin failures++; $display("[TB] FAIL sat_count got=%0h exp=3", rd); end
        writeReg(2'd2, 32'hFFFF_FFFF);
        readReg(2'd2, rd);
        checks++;
        if (rd !== 32'd0) begin failures++; $display("[TB] FAIL sat_clear got=%0h exp=0", rd); end
        btn_raw[0] = 1'b1; tick(8);
        btn_raw[0] = 1'b0; tick(8);
        readReg(2'd2, rd);
        checks++;
        if (rd !== 32'd1) begin failures++; $display("[TB] FAIL sat_restart got=%0h exp=1", rd); end
        writeReg(2'd1, 32'd3);
        writeReg(2'd2, 32'd0);
    endtask

    task automatic test_interrupt;
        logic [31:0] rd;
        writeReg(2'd3, 32'd2);
        readReg(2'd3, rd);
        checks++;
        if (rd !== 32'd2) begin failures++; $display("[TB] FAIL irqen_readback got=%0h exp=2", rd); end
        btn_raw[0] = 1'b1;
        tick(8);
        checks++;
        if (irq !== 1'b0) begin failures++; $display("[TB] FAIL irq_masked got=%0b exp=0", irq); end
        btn_raw[1] = 1'b1;
        tick(6);
        readReg(2'd1, rd);
        checks++;
        if (rd !== 32'd3) begin failures++; $display("[TB] FAIL irq_pressed got=%0h exp=3", rd); end
        checks++;
        if (irq !== 1'b0) begin failures++; $display("[TB] FAIL irq_not_yet got=%0b exp=0", irq); end
        tick(1);
        checks++;
        if (irq !== 1'b1) begin failures++; $display("[TB] FAIL irq_asserted got=%0b exp=1", irq); end
        writeReg(2'd1, 32'd2);
        checks++;
        if (irq !== 1'b1) begin failures++; $display("[TB] FAIL irq_hold got=%0b exp=1", irq); end
        tick(1);
        checks++;
        if (irq !== 1'b0) begin failures++; $display("[TB] FAIL irq_cleared got=%0b exp=0", irq); end
    endtask

    task automatic test_bus_isolation;
        logic [31:0] rd;
        sel = 1'b0; we = 1'b1; addr = 2'd3; data_in = 32'd3;
        #1;
        checks++;
        if (data_out !== 32'd0) begin failures++; $display("[TB] FAIL unselected_data got=%0h exp=0", data_out); end
        tick(1);
        we = 1'b0; data_in = '0;
        readReg(2'd3, rd);
        checks++;
        if (rd !== 32'd2) begin failures++; $display("[TB] FAIL unselected_write got=%0h exp=2", rd); end
        writeReg(2'd0, 32'd0);
        readReg(2'd0, rd);
        checks++;
        if (rd !== 32'd3) begin failures++; $display("[TB] FAIL map_state got=%0h exp=3", rd); end
        readReg(2'd1, rd);
        checks++;
        if (rd !== 32'd1) begin failures++; $display("[TB] FAIL map_pressed got=%0h exp=1", rd); end
        readReg(2'd2, rd);
        checks++;
        if (rd !== 32'd2) begin failures++; $display("[TB] FAIL map_count got=%0h exp=2", rd); end
        writeReg(2'd3, 32'hFFFF_FFFD);
        readReg(2'd3, rd);
        checks++;
        if (rd !== 32'd1) begin failures++; $display("[TB] FAIL map_irqen got=%0h exp=1", rd); end
        tick(1);
        checks++;
        if (irq !== 1'b1) begin failures++; $display("[TB] FAIL irq_remask got=%0b exp=1", irq); end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_w1c_race();
        test_saturation();
        test_interrupt();
        test_bus_isolation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/xbutton_ctrl.md
Name: xbutton_ctrl

Overview:
Push-button peripheral selected by the address decoder's button_sel strobe. It synchronises and debounces N_BTN raw button inputs and captures press events in sticky flags and a press counter. It presents a combinational read word that the decoder muxes onto data_to_rd, and raises a maskable interrupt request.

Parameters:
N_BTN, 2, number of button inputs (1..8)
DEBOUNCE_CYC, 1000, cycles a synchronised input must differ from the stable level before the stable level changes (>=2)
CNT_W, 8, press counter width (<=24)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-low
sel  input  1  button_sel from address decoder
we  input  1  write enable, qualified by sel
addr  input  2  register offset (word address LSBs)
data_in  input  32  write data
data_out  output  32  read data, combinational, 0 when sel=0
btn_raw  input  N_BTN  asynchronous button pins, 1 = pressed
btn_state  output  N_BTN  debounced levels (for LED / debug)
irq  output  1  |(pressed & irq_en), registered

Behaviour:
- Reset (rst=0, async): sync FFs, stable levels, debounce counters, pressed, count, irq_en, irq all 0; data_out=0; btn_state=0.
- Sync: 2-FF synchroniser per bit.
- Debounce, per bit:
  - sync == stable -> counter cleared.
  - Otherwise counter increments; at DEBOUNCE_CYC-1 the stable level takes sync on that edge and the counter clears.
  - Any bounce back clears the counter.
  - Latency raw->btn_state = 2 + DEBOUNCE_CYC cycles.
- Edge: rise = stable_next & ~stable (0->1 transition of the stable level). Releases are not flagged.
- Register map (addr):
  - 0 STATE, RO: {0, stable}.
  - 1 PRESSED, R/W1C: sticky rise flags; a write clears bits where data_in=1.
  - 2 COUNT, R/W: {0, count}; any write clears to 0.
  - 3 IRQ_EN, RW: N_BTN-bit mask, data_in[N_BTN-1:0].
- Writes take effect on the clk edge where sel & we. Reads have no side effects.
- COUNT increments by popcount(rise) per cycle and saturates at 2^CNT_W-1 (no wrap).
- Simultaneous events:
  - rise and W1C on the same PRESSED bit -> set wins.
  - COUNT write and rise in the same cycle -> clear wins and the count stays 0; PRESSED still sets.
- irq updates one cycle after pressed/irq_en change.
- Unused read bits are 0. sel=0 -> data_out=0 and writes are ignored.
- Reset mid-debounce: counter lost; a held button re-qualifies after 2+DEBOUNCE_CYC cycles from reset release and produces one rise.

Test Plan:
- Reset values, DEBOUNCE_CYC=4: hold rst=0 with btn_raw=2'b11 -> all reads 0, irq=0. Release rst -> btn_state=2'b11 exactly 6 cycles later; PRESSED=3, COUNT=2.
- Bounce filtering: toggle btn_raw[0] 1/0 every 2 cycles for 20 cycles, then hold 1 -> exactly one rise; COUNT=1, PRESSED=1. A glitch of DEBOUNCE_CYC-1 cycles causes no change.
- W1C race: write PRESSED data_in=1 in the cycle a bit-0 rise occurs -> PRESSED[0] stays 1. A later write with no rise -> PRESSED=0.
- Saturation, CNT_W=2: 5 separate presses of button 0 -> COUNT=3. A write to COUNT -> 0. The next press -> 1.
- Interrupt: IRQ_EN=2'b10, press button 0 -> irq=0. Press button 1 -> irq=1 one cycle after PRESSED[1] sets. W1C bit 1 -> irq=0 next cycle.
- Bus isolation: sel=0, we=1, addr=3, data_in=3 -> IRQ_EN unchanged, data_out=0. With sel=1 and addr=0..3, data_out matches the register map with upper bits 0.
